// File: rtl/sar_pkg.sv
// rtl/sar_pkg.sv - shared FSM state type and default parameters for the SAR ADC controller
package sar_pkg;

    typedef logic [1:0] sar_state_t;

    localparam sar_state_t ST_IDLE    = 2'd0;
    localparam sar_state_t ST_SAMPLE  = 2'd1;
    localparam sar_state_t ST_CONVERT = 2'd2;
    localparam sar_state_t ST_DONE    = 2'd3;

    localparam int SAR_WIDTH_DEF         = 8;
    localparam int SAR_SAMPLE_CYCLES_DEF = 2;
    localparam int SAR_SETTLE_CYCLES_DEF = 1;

    function automatic int sar_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sar_cmp_sync.sv
// rtl/sar_cmp_sync.sv - two-flop synchronizer for the asynchronous comparator output
module sar_cmp_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/sar_adc_ctrl.sv
// rtl/sar_adc_ctrl.sv - successive-approximation ADC controller; SAR_CMP_SYNC_EN adds a comparator synchronizer
module sar_adc_ctrl
    import sar_pkg::*;
#(
    parameter int WIDTH         = SAR_WIDTH_DEF,
    parameter int SAMPLE_CYCLES = SAR_SAMPLE_CYCLES_DEF,
    parameter int SETTLE_CYCLES = SAR_SETTLE_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_in,
    output logic             sample_o,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             valid,
    input  logic             ready
);

`ifdef SAR_CMP_SYNC_EN
    // Two extra cycles per trial cover the synchronizer delay
    localparam int TRIAL_CYCLES = SETTLE_CYCLES + 2;
`else
    localparam int TRIAL_CYCLES = SETTLE_CYCLES;
`endif
    localparam int CNT_MAX = sar_max(SAMPLE_CYCLES, TRIAL_CYCLES);
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int BW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_CYCLES - 1);
    localparam logic [CW-1:0] TRIAL_LAST  = CW'(TRIAL_CYCLES - 1);

    sar_state_t       state_q, state_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] code_q, code_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] trial_code;
    logic             cmp_bit;

`ifdef SAR_CMP_SYNC_EN
    sar_cmp_sync u_cmp_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (cmp_in),
        .q_o   (cmp_bit)
    );
`else
    assign cmp_bit = cmp_in;
`endif

    assign trial_code = code_q | (WIDTH'(1) << bit_q);

    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        cnt_d    = cnt_q;
        code_d   = code_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SAMPLE;
                    cnt_d   = '0;
                end
            end
            ST_SAMPLE: begin
                if (cnt_q == SAMPLE_LAST) begin
                    state_d = ST_CONVERT;
                    cnt_d   = '0;
                    bit_d   = BW'(WIDTH - 1);
                    code_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_CONVERT: begin
                if (cnt_q == TRIAL_LAST) begin
                    cnt_d  = '0;
                    code_d = cmp_bit ? trial_code : code_q;
                    if (bit_q == '0) begin
                        state_d  = ST_DONE;
                        result_d = cmp_bit ? trial_code : code_q;
                    end else begin
                        bit_d = bit_q - 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            bit_q    <= '0;
            cnt_q    <= '0;
            code_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            bit_q    <= bit_d;
            cnt_q    <= cnt_d;
            code_q   <= code_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        dac_code = '0;
        if (state_q == ST_CONVERT) begin
            dac_code = trial_code;
        end else if (state_q == ST_DONE) begin
            dac_code = result_q;
        end
    end

    assign sample_o = (state_q == ST_SAMPLE);
    assign busy     = (state_q != ST_IDLE);
    assign valid    = (state_q == ST_DONE);
    assign result   = result_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// tb/tb_sar_adc_ctrl.sv - randomized self-checking bench for sar_adc_ctrl against a SAR reference model
module tb_sar_adc_ctrl;

    localparam int W  = 8;
    localparam int S  = 2;
    localparam int ST = 1;
`ifdef SAR_CMP_SYNC_EN
    localparam int T       = ST + 2;
    localparam int LAT_LIT = 26;
`else
    localparam int T       = ST;
    localparam int LAT_LIT = 10;
`endif
    localparam int L = S + W * T;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         ready = 1'b0;
    logic [W-1:0] vin = '0;
    logic         cmp_in;
    logic         sample_o;
    logic [W-1:0] dac_code;
    logic         busy;
    logic [W-1:0] result;
    logic         valid;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic         smp;
        logic [W-1:0] dac;
        logic         bsy;
        logic         vld;
        logic [W-1:0] res;
    } exp_t;

    exp_t exp_q[$];

    sar_adc_ctrl #(.WIDTH(W), .SAMPLE_CYCLES(S), .SETTLE_CYCLES(ST)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .cmp_in   (cmp_in),
        .sample_o (sample_o),
        .dac_code (dac_code),
        .busy     (busy),
        .result   (result),
        .valid    (valid),
        .ready    (ready)
    );

    assign cmp_in = (vin >= dac_code);

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, expv);
        end
    endtask

    // Trial k of a binary search on v (k=W gives the final code)
    function automatic logic [W-1:0] trial_code(input logic [W-1:0] v, input int k);
        logic [W-1:0] kept;
        logic [W-1:0] t;
        kept = '0;
        for (int b = W - 1; b >= 0; b--) begin
            t = kept | (W'(1) << b);
            if (W - 1 - b == k) return t;
            if (v >= t) kept = t;
        end
        return kept;
    endfunction

    function automatic exp_t idle_e();
        return '{smp: 1'b0, dac: '0, bsy: 1'b0, vld: 1'b0, res: '0};
    endfunction

    task automatic build(input logic [W-1:0] v, input int hold, output exp_t seq[$]);
        logic [W-1:0] r;
        seq = {};
        r = trial_code(v, W);
        for (int i = 0; i < S; i++) seq.push_back('{smp: 1'b1, dac: '0, bsy: 1'b1, vld: 1'b0, res: '0});
        for (int k = 0; k < W; k++)
            for (int t = 0; t < T; t++)
                seq.push_back('{smp: 1'b0, dac: trial_code(v, k), bsy: 1'b1, vld: 1'b0, res: '0});
        for (int h = 0; h < hold; h++) seq.push_back('{smp: 1'b0, dac: r, bsy: 1'b1, vld: 1'b1, res: r});
        seq.push_back(idle_e());
    endtask

    initial begin : compare
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sample_o", {31'b0, sample_o}, {31'b0, e.smp});
                chk("dac_code", {24'b0, dac_code}, {24'b0, e.dac});
                chk("busy", {31'b0, busy}, {31'b0, e.bsy});
                chk("valid", {31'b0, valid}, {31'b0, e.vld});
                if (e.vld) chk("result", {24'b0, result}, {24'b0, e.res});
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start = 1'b0;
            ready = 1'b0;
            exp_q.push_back(idle_e());
        end
    endtask

    task automatic convert(input logic [W-1:0] v, input int hold, input bit ign, input bit early,
                           output logic [W-1:0] got, output int lat);
        exp_t seq[$];
        build(v, hold, seq);
        got = '0;
        lat = -1;
        @(negedge clk);
        vin   = v;
        start = 1'b1;
        ready = early ? 1'($urandom_range(0, 1)) : 1'b0;
        foreach (seq[j]) exp_q.push_back(seq[j]);
        for (int i = 0; i <= L + hold; i++) begin
            @(negedge clk);
            if (valid && lat < 0) lat = i;
            if (i == L) got = result;
            start = (ign && i < L + hold) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (i < L)                 ready = early ? 1'($urandom_range(0, 1)) : 1'b0;
            else if (i == L + hold - 1) ready = 1'b1;
            else                       ready = 1'b0;
            if (i == L + hold) exp_q.push_back(idle_e());
        end
    endtask

    task automatic abort_conv(input logic [W-1:0] v, input int ab);
        exp_t seq[$];
        build(v, 1, seq);
        @(negedge clk);
        vin   = v;
        start = 1'b1;
        ready = 1'b0;
        for (int j = 0; j <= ab; j++) exp_q.push_back(seq[j]);
        for (int i = 0; i <= ab; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_sample_o", {31'b0, sample_o}, 32'd0);
        chk("rst_mid_dac_code", {24'b0, dac_code}, 32'd0);
        chk("rst_mid_busy", {31'b0, busy}, 32'd0);
        chk("rst_mid_valid", {31'b0, valid}, 32'd0);
        chk("rst_mid_result", {24'b0, result}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [W-1:0] a5_tbl [8];

    initial begin : main
        logic [W-1:0] got;
        int           lat;
        a5_tbl = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

        #1 rst_n = 1'b0;
        #12;
        chk("reset_sample_o", {31'b0, sample_o}, 32'd0);
        chk("reset_dac_code", {24'b0, dac_code}, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_valid", {31'b0, valid}, 32'd0);
        chk("reset_result", {24'b0, result}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);

        for (int k = 0; k < 8; k++) chk($sformatf("model_trial_%0d", k), {24'b0, trial_code(8'hA5, k)}, {24'b0, a5_tbl[k]});
        chk("model_res_A5", {24'b0, trial_code(8'hA5, W)}, 32'hA5);

        convert(8'hA5, 1, 1'b0, 1'b0, got, lat);
        chk("res_A5", {24'b0, got}, 32'hA5);
        chk("latency_A5", lat, LAT_LIT);
        convert(8'h00, 1, 1'b0, 1'b0, got, lat);
        chk("res_00", {24'b0, got}, 32'h00);
        chk("latency_00", lat, LAT_LIT);
        convert(8'hFF, 1, 1'b0, 1'b0, got, lat);
        chk("res_FF", {24'b0, got}, 32'hFF);
        chk("latency_FF", lat, LAT_LIT);

        convert(8'hA5, 6, 1'b0, 1'b0, got, lat);
        chk("res_A5_held", {24'b0, got}, 32'hA5);
        convert(8'($urandom), 2, 1'b1, 1'b0, got, lat);
        convert(8'($urandom), 3, 1'b1, 1'b1, got, lat);

        abort_conv(8'h77, S + 3 * T);
        idle(2);
        convert(8'h3C, 1, 1'b0, 1'b0, got, lat);
        chk("res_3C_after_reset", {24'b0, got}, 32'h3C);

        for (int n = 0; n < 20; n++) begin
            convert(8'($urandom), int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), got, lat);
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
        end

        idle(2);
        @(posedge clk);
        #3;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
